alu_bitserial_seq: RTL and testbench

Multi-cycle sequencer that runs one 1-bit ALU slice across a WIDTH-bit operand pair, LSB first, one bit per clock. It captures operands and opcode on a start handshake and keeps the slice's two carry chains in flip-flops. It assembles the result in a shift register and produces zero/negative/overflow/carry flags. It is the area-minimal ALU option for the CPU datapath and shares opcode encoding with the parallel ALU.

---
 rtl/alu_bitserial_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_bitserial_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: one 1-bit slice is stepped across a WIDTH-bit operand
// pair LSB first, with the add and subtract carry chains held in flip-flops.
module alu_bitserial_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry0_q;
    logic             carry1_q;

    logic             slice_bit_d;
    logic             slice_c0_d;
    logic             slice_c1_d;
    logic             b_inv_d;
    logic             arith_d;
    logic             msb_cin_d;
    logic             msb_cout_d;
    logic [WIDTH-1:0] res_next_d;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_PASS, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // 1-bit ALU slice; chain 0 computes a+b, chain 1 computes a+~b+1
    always_comb begin
        b_inv_d     = ~b_sr_q[0];
        slice_c0_d  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry0_q) | (b_sr_q[0] & carry0_q);
        slice_c1_d  = (a_sr_q[0] & b_inv_d) | (a_sr_q[0] & carry1_q) | (b_inv_d & carry1_q);
        slice_bit_d = 1'b0;
        case (op_q)
            OP_PASS: slice_bit_d = b_sr_q[0];
            OP_ADD:  slice_bit_d = a_sr_q[0] ^ b_sr_q[0] ^ carry0_q;
            OP_SUB:  slice_bit_d = a_sr_q[0] ^ b_inv_d ^ carry1_q;
            OP_AND:  slice_bit_d = a_sr_q[0] & b_sr_q[0];
            OP_OR:   slice_bit_d = a_sr_q[0] | b_sr_q[0];
            OP_XOR:  slice_bit_d = a_sr_q[0] ^ b_sr_q[0];
            default: slice_bit_d = 1'b0;
        endcase
        res_next_d = {slice_bit_d, res_sr_q[WIDTH-1:1]};
    end

    // MSB carry-in/out of whichever chain the latched opcode uses
    always_comb begin
        arith_d    = 1'b0;
        msb_cin_d  = 1'b0;
        msb_cout_d = 1'b0;
        case (op_q)
            OP_ADD: begin
                arith_d    = 1'b1;
                msb_cin_d  = carry0_q;
                msb_cout_d = slice_c0_d;
            end
            OP_SUB: begin
                arith_d    = 1'b1;
                msb_cin_d  = carry1_q;
                msb_cout_d = slice_c1_d;
            end
            default: begin
                arith_d    = 1'b0;
                msb_cin_d  = 1'b0;
                msb_cout_d = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered handshake, result and flag outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            res_sr_q  <= '0;
            op_q      <= 3'b000;
            cnt_q     <= '0;
            carry0_q  <= 1'b0;
            carry1_q  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        result    <= '0;
                        zero      <= 1'b0;
                        negative  <= 1'b0;
                        overflow  <= 1'b0;
                        carry_out <= 1'b0;
                        if (op_legal(control)) begin
                            a_sr_q   <= a;
                            b_sr_q   <= b;
                            op_q     <= control;
                            res_sr_q <= '0;
                            cnt_q    <= '0;
                            carry0_q <= 1'b0;
                            carry1_q <= 1'b1;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            state_q  <= S_RUN;
                        end else begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    res_sr_q <= res_next_d;
                    carry0_q <= slice_c0_d;
                    carry1_q <= slice_c1_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= res_next_d;
                        zero      <= (res_next_d == '0);
                        negative  <= res_next_d[WIDTH-1];
                        overflow  <= arith_d & (msb_cin_d ^ msb_cout_d);
                        carry_out <= arith_d & msb_cout_d;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Scoreboarded bench for alu_bitserial_seq at WIDTH=8: directed corner cases plus
// random operations checked against an arithmetic reference model.
module tb_alu_bitserial_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   control = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, err, zero, negative, overflow, carry_out;
    logic [W-1:0] result;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         v;
        logic         c;
        logic         e;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_now = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;

    alu_bitserial_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .control(control),
        .a(a), .b(b), .busy(busy), .done(done), .err(err), .result(result),
        .zero(zero), .negative(negative), .overflow(overflow), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        exp_t e;
        int   sx, sy, s;
        logic [W:0] wide;
        e  = '0;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            3'b000: e.r = y;
            3'b010: begin
                wide = {1'b0, x} + {1'b0, y};
                e.r  = wide[W-1:0];
                e.c  = wide[W];
                s    = sx + sy;
                e.v  = (s > 127) || (s < -128);
            end
            3'b011: begin
                e.r = x - y;
                e.c = (x >= y);
                s   = sx - sy;
                e.v = (s > 127) || (s < -128);
            end
            3'b100: e.r = x & y;
            3'b101: e.r = x | y;
            3'b110: e.r = x ^ y;
            default: begin
                e.e = 1'b1;
                return e;
            end
        endcase
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    // Cycle counter and scoreboard monitor, sampled away from the rising edge
    always @(negedge clk) begin
        cyc_now++;
        if (done) begin
            exp_t e;
            done_cnt++;
            last_done_cyc = cyc_now;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(result), 64'(e.r));
                chk("zero", 64'(zero), 64'(e.z));
                chk("negative", 64'(negative), 64'(e.n));
                chk("overflow", 64'(overflow), 64'(e.v));
                chk("carry_out", 64'(carry_out), 64'(e.c));
                chk("err", 64'(err), 64'(e.e));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        int  cyc;
        bit  legal;
        bit  got;
        legal = (op != 3'b001) && (op != 3'b111);
        @(negedge clk);
        a = x;
        b = y;
        control = op;
        start = 1'b1;
        exp_q.push_back(model(x, y, op));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        control = 3'($urandom);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (legal && cyc == 1) chk("err_cleared", 64'(err), 64'd0);
            if (cyc <= W) chk("busy", 64'(busy), legal ? 64'd1 : 64'd0);
            got = done;
        end
        chk("latency", 64'(cyc), legal ? 64'(W + 1) : 64'd1);
    endtask

    initial begin
        int d0;
        int first_done;
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({zero, negative, overflow, carry_out}), 64'd0);
        reset = 1'b0;

        run_op(8'h7F, 8'h01, 3'b010);
        run_op(8'h05, 8'h05, 3'b011);
        run_op(8'h00, 8'h01, 3'b011);
        run_op(8'hCC, 8'hAA, 3'b100);
        run_op(8'hCC, 8'hAA, 3'b101);
        run_op(8'hF0, 8'hFF, 3'b110);
        run_op(8'h55, 8'h3C, 3'b000);
        run_op(8'hFF, 8'h01, 3'b010);
        run_op(8'h80, 8'h01, 3'b011);
        run_op(8'hFF, 8'h00, 3'b111);
        run_op(8'h12, 8'h34, 3'b001);
        run_op(8'h12, 8'h34, 3'b010);

        // start held high: exactly two ops, dones W+2 cycles apart
        @(negedge clk);
        a = 8'h40;
        b = 8'h41;
        control = 3'b010;
        start = 1'b1;
        e = model(8'h40, 8'h41, 3'b010);
        exp_q.push_back(e);
        exp_q.push_back(e);
        d0 = done_cnt;
        first_done = 0;
        for (int i = 0; i < 60 && done_cnt < d0 + 2; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt == d0 + 1 && first_done == 0) first_done = last_done_cyc;
        end
        start = 1'b0;
        chk("held_start_dones", 64'(done_cnt - d0), 64'd2);
        chk("b2b_spacing", 64'(last_done_cyc - first_done), 64'(W + 2));
        repeat (12) @(negedge clk);
        chk("held_start_no_extra", 64'(done_cnt - d0), 64'd2);

        // reset in cycle 4 of an add aborts it
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        control = 3'b010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(8'h01, 8'h01, 3'b010);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_op(W'($urandom), W'($urandom), op);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
